// File: rtl/lvt_read_stage_pipelined.sv
// Read side of the LVT multi-ported memory: aligns the LVT bank select with the bank
// read data, forwards writes that storage cannot yet show, and registers one word per read port.
module lvt_read_stage_pipelined #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 512,
  parameter int PORTS    = 2,
  parameter int RPORTS   = 2,
  parameter int LVT_LAT  = 3,
  parameter int BANK_LAT = 2,
  parameter int WR_VIS   = 3,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [RPORTS-1:0]             rd_valid,
  input  logic [RPORTS*AW-1:0]          rd_addr,
  output logic [RPORTS*AW-1:0]          lvt_raddr,
  output logic [RPORTS*AW-1:0]          bank_raddr,
  input  logic [RPORTS*SW-1:0]          lvt_sel,
  input  logic [RPORTS*PORTS*WIDTH-1:0] bank_rdata,
  input  logic [PORTS-1:0]              wr_en,
  input  logic [PORTS*AW-1:0]           wr_addr,
  input  logic [PORTS*WIDTH-1:0]        wr_data,
  output logic [RPORTS-1:0]             rd_data_valid,
  output logic [RPORTS*WIDTH-1:0]       rd_data,
  output logic [15:0]                   fwd_count
);

  localparam int L       = (LVT_LAT > BANK_LAT) ? LVT_LAT : BANK_LAT;
  localparam int SEL_DLY = (BANK_LAT > LVT_LAT) ? (BANK_LAT - LVT_LAT) : 0;
  localparam int DAT_DLY = (LVT_LAT > BANK_LAT) ? (LVT_LAT - BANK_LAT) : 0;
  localparam int HN      = WR_VIS - 1;
  localparam int HD      = (HN > 0) ? HN : 1;

  assign lvt_raddr  = rd_addr;
  assign bank_raddr = rd_addr;

  logic [PORTS-1:0]       hist_en   [HD];
  logic [PORTS*AW-1:0]    hist_addr [HD];
  logic [PORTS*WIDTH-1:0] hist_data [HD];

  // Entry 0 holds last cycle's writes; older entries shift toward HD-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < HD; k++) begin
        hist_en[k]   <= '0;
        hist_addr[k] <= '0;
        hist_data[k] <= '0;
      end
    end else begin
      for (int k = HD - 1; k > 0; k--) begin
        hist_en[k]   <= hist_en[k-1];
        hist_addr[k] <= hist_addr[k-1];
        hist_data[k] <= hist_data[k-1];
      end
      hist_en[0]   <= (HN > 0) ? wr_en : '0;
      hist_addr[0] <= wr_addr;
      hist_data[0] <= wr_data;
    end
  end

  logic [RPORTS-1:0]       fwd_hit;
  logic [RPORTS*WIDTH-1:0] fwd_word;

  // Oldest entry and lowest port scanned first so the youngest, highest-port match wins.
  always_comb begin
    fwd_hit  = '0;
    fwd_word = '0;
    for (int r = 0; r < RPORTS; r++) begin
      for (int k = HN - 1; k >= 0; k--) begin
        for (int b = 0; b < PORTS; b++) begin
          if (hist_en[k][b] && (hist_addr[k][b*AW +: AW] == rd_addr[r*AW +: AW])) begin
            fwd_hit[r]                  = 1'b1;
            fwd_word[r*WIDTH +: WIDTH]  = hist_data[k][b*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  logic [RPORTS-1:0]       vld_pipe [L];
  logic [RPORTS-1:0]       hit_pipe [L];
  logic [RPORTS*WIDTH-1:0] fwd_pipe [L];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < L; k++) begin
        vld_pipe[k] <= '0;
        hit_pipe[k] <= '0;
        fwd_pipe[k] <= '0;
      end
    end else begin
      vld_pipe[0] <= rd_valid;
      hit_pipe[0] <= fwd_hit & rd_valid;
      fwd_pipe[0] <= fwd_word;
      for (int k = 1; k < L; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        hit_pipe[k] <= hit_pipe[k-1];
        fwd_pipe[k] <= fwd_pipe[k-1];
      end
    end
  end

  logic [RPORTS*SW-1:0]          sel_aligned;
  logic [RPORTS*PORTS*WIDTH-1:0] bank_aligned;

  if (SEL_DLY > 0) begin : g_sel_dly
    logic [RPORTS*SW-1:0] sel_sr [SEL_DLY];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < SEL_DLY; k++) sel_sr[k] <= '0;
      end else begin
        sel_sr[0] <= lvt_sel;
        for (int k = 1; k < SEL_DLY; k++) sel_sr[k] <= sel_sr[k-1];
      end
    end
    assign sel_aligned = sel_sr[SEL_DLY-1];
  end else begin : g_sel_direct
    assign sel_aligned = lvt_sel;
  end

  if (DAT_DLY > 0) begin : g_dat_dly
    logic [RPORTS*PORTS*WIDTH-1:0] dat_sr [DAT_DLY];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < DAT_DLY; k++) dat_sr[k] <= '0;
      end else begin
        dat_sr[0] <= bank_rdata;
        for (int k = 1; k < DAT_DLY; k++) dat_sr[k] <= dat_sr[k-1];
      end
    end
    assign bank_aligned = dat_sr[DAT_DLY-1];
  end else begin : g_dat_direct
    assign bank_aligned = bank_rdata;
  end

  logic [RPORTS*WIDTH-1:0] out_word;
  logic [16:0]             fwd_sum;

  // An out-of-range select leaves the word at zero; a forward hit overrides the bank.
  always_comb begin
    out_word = '0;
    fwd_sum  = {1'b0, fwd_count};
    for (int r = 0; r < RPORTS; r++) begin
      for (int b = 0; b < PORTS; b++) begin
        if (int'(sel_aligned[r*SW +: SW]) == b)
          out_word[r*WIDTH +: WIDTH] = bank_aligned[(r*PORTS+b)*WIDTH +: WIDTH];
      end
      if (hit_pipe[L-1][r]) begin
        out_word[r*WIDTH +: WIDTH] = fwd_pipe[L-1][r*WIDTH +: WIDTH];
        if (vld_pipe[L-1][r]) fwd_sum = fwd_sum + 17'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_valid <= '0;
      rd_data       <= '0;
      fwd_count     <= '0;
    end else begin
      rd_data_valid <= vld_pipe[L-1];
      for (int r = 0; r < RPORTS; r++) begin
        if (vld_pipe[L-1][r]) rd_data[r*WIDTH +: WIDTH] <= out_word[r*WIDTH +: WIDTH];
      end
      fwd_count <= fwd_sum[16] ? 16'hFFFF : fwd_sum[15:0];
    end
  end

  for (genvar r = 0; r < RPORTS; r++) begin : g_sel_chk
    a_sel_legal: assert property (@(posedge clk) disable iff (!rst_n)
      vld_pipe[L-1][r] |-> (int'(sel_aligned[r*SW +: SW]) < PORTS));
  end

endmodule
